fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Parametrised instruction fetch front end that replaces the fixed-offset IFU/IFU_CONTROL pair.
- Fetches sequential instructions from instruction memory over a valid handshake, with one request outstanding at a time.
- Buffers fetched words with their PCs in a DEPTH-entry prefetch FIFO that feeds the decode unit.
- Supports halt and PC redirect (jump/branch flush).

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 32'h00000000, fetch PC after reset (low 2 bits must be 0)
PC_STEP, 4, PC increment per fetched word

Ports:
clock_in  input  1  core clock
reset_in  input  1  synchronous active-high reset
halt_in  input  1  stop issuing new fetches; FIFO keeps draining
redirect_valid_in  input  1  flush and restart fetch at redirect_addr_in
redirect_addr_in  input  XLEN  new fetch PC; bits[1:0] forced to 0
mem_addr_out  output  XLEN  fetch address (= fetch_pc)
mem_read_out  output  1  fetch request active
mem_data_in  input  ILEN  fetched word
mem_valid_in  input  1  completes request when mem_read_out=1
ins_valid_out  output  1  FIFO head valid
ins_data_out  output  ILEN  head instruction (0 when empty)
ins_pc_out  output  XLEN  head PC (0 when empty)
ins_ready_in  input  1  decode accepts head
fifo_count_out  output  clog2(DEPTH+1)  occupied entries
state_out  output  2  debug: 0 IDLE, 1 FETCH, 2 HALTED, 3 DISCARD

Behaviour:
Clock is clock_in. Reset is reset_in: synchronous, active-high.

Reset values:
- fetch_pc=RESET_PC; rd/wr pointers=0; count=0; state=IDLE.
- mem_read_out=0, ins_valid_out=0, ins_data_out=0, ins_pc_out=0.
- Reset mid-FETCH abandons the request. mem_read_out drops the next cycle, and any late mem_valid_in is ignored.

Outputs:
- mem_read_out = (state==FETCH || state==DISCARD).
- mem_addr_out = fetch_pc, held stable while mem_read_out=1.
- A transfer completes on any cycle where mem_read_out && mem_valid_in. mem_valid_in is ignored otherwise.

State machine (redirect has highest priority in every state):
- IDLE:
  - halt_in -> HALTED.
  - else count<DEPTH -> FETCH.
  - else stay.
- FETCH:
  - On completion, push {mem_data_in, fetch_pc}; fetch_pc += PC_STEP (wraps modulo 2^XLEN).
  - Next state: halt_in -> HALTED; else if count after this cycle's push/pop < DEPTH -> FETCH (back-to-back, new address next cycle); else IDLE.
  - Without completion, stay. Halt does not cancel an outstanding request.
- HALTED: no requests; !halt_in -> IDLE.
- DISCARD: on completion, drop the data (no push, fetch_pc unchanged) -> IDLE.

Redirect (redirect_valid_in=1):
- FIFO flushed (count=0, pointers=0).
- fetch_pc = {redirect_addr_in[XLEN-1:2], 2'b00}.
- Next state: if in FETCH/DISCARD with no completion this cycle -> DISCARD; otherwise IDLE. A completion in the same cycle is dropped.
- Redirect during HALTED -> IDLE, and re-halts next cycle if halt_in is still set.
- A head pop in the same cycle is still treated as consumed by decode; the FIFO state is the flushed state.

FIFO:
- First-word fall-through; ins_valid_out = (count!=0).
- Pop on ins_valid_out && ins_ready_in. Push and pop in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH.
- Overflow is impossible: requests issue only when count<DEPTH, and count cannot grow while a request is outstanding.
- Latency: completion at cycle N -> ins_valid_out at N+1 (when the FIFO was empty).
- Peak throughput: 1 instruction/cycle with a 1-cycle memory.

Test Plan:
- Reset, memory returns valid every cycle, ins_ready_in=1 -> mem_addr_out 0,4,8,...; ins_pc_out 0,4,8 from cycle 3, one word per cycle, data matches memory.
- ins_ready_in=0, DEPTH=4 -> exactly 4 completions, fifo_count_out=4, state IDLE, mem_read_out=0. Raise ready -> pops 0,4,8,12, then fetch resumes at 16.
- Memory latency 3 cycles, redirect to 0x103 on the 2nd wait cycle -> state DISCARD, stale word dropped, next request at 0x100, FIFO empty until its completion.
- halt_in raised mid-request -> request completes and is pushed, state HALTED, no further mem_read_out. Drop halt -> fetch resumes at next sequential PC.
- Simultaneous push and pop with count=2 -> count stays 2, order preserved. Redirect and completion in the same cycle -> completion dropped, count=0, next address = redirect target.
- Assert reset_in during FETCH with count=3 -> next cycle all outputs at reset values; late mem_valid_in ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request channel and decode-side FIFO head.
interface fetch_prefetch_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
);

  // Instruction memory side
  logic [XLEN-1:0] mem_addr_out;
  logic            mem_read_out;
  logic [ILEN-1:0] mem_data_in;
  logic            mem_valid_in;

  // Decode side
  logic            ins_valid_out;
  logic [ILEN-1:0] ins_data_out;
  logic [XLEN-1:0] ins_pc_out;
  logic            ins_ready_in;

  // Fetch unit view
  modport master (
    output mem_addr_out,
    output mem_read_out,
    input  mem_data_in,
    input  mem_valid_in,
    output ins_valid_out,
    output ins_data_out,
    output ins_pc_out,
    input  ins_ready_in
  );

  // Memory / decode environment view
  modport slave (
    input  mem_addr_out,
    input  mem_read_out,
    output mem_data_in,
    output mem_valid_in,
    input  ins_valid_out,
    input  ins_data_out,
    input  ins_pc_out,
    output ins_ready_in
  );

endinterface

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction fetch with a single outstanding memory request,
// a first-word fall-through prefetch FIFO toward decode, halt and redirect.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic                       halt_in,
  input  logic                       redirect_valid_in,
  input  logic [XLEN-1:0]            redirect_addr_in,
  fetch_prefetch_unit_if.master      bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_out,
  output logic [1:0]                 state_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  STEP_C  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  typedef struct packed {
    logic [ILEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  entry_t          fifo_q [DEPTH];

  logic             mem_read_c;
  logic             complete_c;
  logic             push_c;
  logic             pop_c;
  logic             fifo_nonempty_c;
  logic [CNT_W-1:0] count_next_c;

  // Handshake decode: a request is live in FETCH and DISCARD; only FETCH keeps data
  always_comb begin
    mem_read_c      = (state == ST_FETCH) || (state == ST_DISCARD);
    complete_c      = mem_read_c && bus.mem_valid_in;
    fifo_nonempty_c = (count != '0);
    pop_c           = fifo_nonempty_c && bus.ins_ready_in;
    push_c          = complete_c && (state == ST_FETCH) && !redirect_valid_in;
    count_next_c    = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Control state: FSM, fetch PC, FIFO pointers and occupancy; redirect overrides all
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_addr_in & ALIGN_MASK;
      // A request still in flight must be drained before a new one can issue
      state    <= (mem_read_c && !bus.mem_valid_in) ? ST_DISCARD : ST_IDLE;
    end else begin
      if (push_c) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + STEP_C;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next_c;

      case (state)
        ST_IDLE: begin
          if (halt_in) begin
            state <= ST_HALTED;
          end else if (count < DEPTH_C) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Halt waits for the outstanding request to complete
          if (complete_c) begin
            if (halt_in) begin
              state <= ST_HALTED;
            end else if (count_next_c < DEPTH_C) begin
              state <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HALTED: begin
          if (!halt_in) begin
            state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (complete_c) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage: word plus the PC it was fetched from
  always_ff @(posedge clock_in) begin
    if (!reset_in && push_c) begin
      fifo_q[wr_ptr] <= '{data: bus.mem_data_in, pc: fetch_pc};
    end
  end

  // Outputs are decoded straight from registered state; head reads as zero when empty
  always_comb begin
    bus.mem_read_out  = mem_read_c;
    bus.mem_addr_out  = fetch_pc;
    bus.ins_valid_out = fifo_nonempty_c;
    bus.ins_data_out  = '0;
    bus.ins_pc_out    = '0;
    if (fifo_nonempty_c) begin
      bus.ins_data_out = fifo_q[rd_ptr].data;
      bus.ins_pc_out   = fifo_q[rd_ptr].pc;
    end
    fifo_count_out = count;
    state_out      = state;
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (expected PC sequence and memory contents).
module tb_fetch_prefetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            halt;
  logic            redir;
  logic [XLEN-1:0] raddr;
  logic [2:0]      fifo_count;
  logic [1:0]      state;

  int checks = 0;
  int errors = 0;

  fetch_prefetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_prefetch_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clock_in          (clk),
    .reset_in          (rst),
    .halt_in           (halt),
    .redirect_valid_in (redir),
    .redirect_addr_in  (raddr),
    .bus               (bus),
    .fifo_count_out    (fifo_count),
    .state_out         (state)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a fixed function of address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.mem_data_in = memfn(bus.mem_addr_out);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redir = 1'b0; raddr = '0;
    bus.mem_valid_in = 1'b0; bus.ins_ready_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_read"}, 64'(bus.mem_read_out), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr_out), 64'd0);
    check({tag, "_ins_valid"}, 64'(bus.ins_valid_out), 64'd0);
    check({tag, "_ins_data"}, 64'(bus.ins_data_out), 64'd0);
    check({tag, "_ins_pc"}, 64'(bus.ins_pc_out), 64'd0);
    check({tag, "_count"}, 64'(fifo_count), 64'd0);
    check({tag, "_state"}, 64'(state), 64'd0);
  endtask

  logic [31:0] exp_pc;
  logic        prev_pend;
  logic [31:0] prev_addr;
  int          pops;

  initial begin
    // ---- reset values, then streaming with a 1-cycle memory ----
    do_reset();
    check_reset_values("rst");
    bus.mem_valid_in = 1'b1; bus.ins_ready_in = 1'b1;
    tick();
    check("s1_read", 64'(bus.mem_read_out), 64'd1);
    check("s1_addr0", 64'(bus.mem_addr_out), 64'd0);
    tick();
    check("s1_addr1", 64'(bus.mem_addr_out), 64'd4);
    check("s1_valid", 64'(bus.ins_valid_out), 64'd1);
    check("s1_pc0", 64'(bus.ins_pc_out), 64'd0);
    check("s1_data0", 64'(bus.ins_data_out), 64'(memfn(32'd0)));
    for (int k = 2; k < 6; k++) begin
      tick();
      check("s1_addr", 64'(bus.mem_addr_out), 64'(4 * k));
      check("s1_pc", 64'(bus.ins_pc_out), 64'(4 * (k - 1)));
      check("s1_data", 64'(bus.ins_data_out), 64'(memfn(32'(4 * (k - 1)))));
    end

    // ---- FIFO fills with decode stalled, then drains and fetch resumes ----
    do_reset();
    bus.mem_valid_in = 1'b1; bus.ins_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_state", 64'(state), 64'd0);
    check("full_read", 64'(bus.mem_read_out), 64'd0);
    tick(); tick();
    check("full_count_hold", 64'(fifo_count), 64'd4);
    bus.ins_ready_in = 1'b1;
    check("drain_pc0", 64'(bus.ins_pc_out), 64'd0);
    tick();
    check("drain_pc1", 64'(bus.ins_pc_out), 64'd4);
    check("drain_state_idle", 64'(state), 64'd0);
    tick();
    check("drain_pc2", 64'(bus.ins_pc_out), 64'd8);
    check("resume_state", 64'(state), 64'd1);
    check("resume_addr", 64'(bus.mem_addr_out), 64'd16);
    tick();
    check("drain_pc3", 64'(bus.ins_pc_out), 64'd12);
    tick();
    check("drain_pc4", 64'(bus.ins_pc_out), 64'd16);

    // ---- redirect during a slow request ----
    do_reset();
    bus.mem_valid_in = 1'b0; bus.ins_ready_in = 1'b1;
    tick();
    check("slow_addr", 64'(bus.mem_addr_out), 64'd0);
    tick();
    redir = 1'b1; raddr = 32'h103;
    tick();
    redir = 1'b0;
    check("disc_state", 64'(state), 64'd3);
    check("disc_read", 64'(bus.mem_read_out), 64'd1);
    check("disc_count", 64'(fifo_count), 64'd0);
    bus.mem_valid_in = 1'b1;
    tick();
    check("disc_done_state", 64'(state), 64'd0);
    check("disc_dropped", 64'(bus.ins_valid_out), 64'd0);
    bus.mem_valid_in = 1'b0;
    tick();
    check("redir_addr", 64'(bus.mem_addr_out), 64'h100);
    check("redir_read", 64'(bus.mem_read_out), 64'd1);
    check("redir_empty", 64'(bus.ins_valid_out), 64'd0);
    bus.mem_valid_in = 1'b1;
    tick();
    check("redir_pc", 64'(bus.ins_pc_out), 64'h100);
    check("redir_data", 64'(bus.ins_data_out), 64'(memfn(32'h100)));

    // ---- halt mid-request ----
    do_reset();
    bus.mem_valid_in = 1'b0; bus.ins_ready_in = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    check("halt_pending_state", 64'(state), 64'd1);
    check("halt_pending_read", 64'(bus.mem_read_out), 64'd1);
    bus.mem_valid_in = 1'b1;
    tick();
    check("halted_state", 64'(state), 64'd2);
    check("halted_count", 64'(fifo_count), 64'd1);
    check("halted_read", 64'(bus.mem_read_out), 64'd0);
    check("halted_pc", 64'(bus.ins_pc_out), 64'd0);
    tick();
    check("halted_still", 64'(bus.mem_read_out), 64'd0);
    halt = 1'b0;
    tick();
    check("unhalt_idle", 64'(state), 64'd0);
    tick();
    check("unhalt_fetch", 64'(state), 64'd1);
    check("unhalt_addr", 64'(bus.mem_addr_out), 64'd4);

    // ---- push and pop together, then redirect colliding with a completion ----
    do_reset();
    bus.mem_valid_in = 1'b1; bus.ins_ready_in = 1'b0;
    tick(); tick(); tick();
    check("pp_count2", 64'(fifo_count), 64'd2);
    bus.ins_ready_in = 1'b1;
    tick();
    check("pp_count_same", 64'(fifo_count), 64'd2);
    check("pp_head", 64'(bus.ins_pc_out), 64'd4);
    bus.mem_valid_in = 1'b0;
    tick();
    check("pp_count1", 64'(fifo_count), 64'd1);
    check("pp_head2", 64'(bus.ins_pc_out), 64'd8);
    bus.mem_valid_in = 1'b1; bus.ins_ready_in = 1'b0;
    redir = 1'b1; raddr = 32'h200;
    tick();
    redir = 1'b0; bus.mem_valid_in = 1'b0;
    check("rc_count", 64'(fifo_count), 64'd0);
    check("rc_valid", 64'(bus.ins_valid_out), 64'd0);
    check("rc_state", 64'(state), 64'd0);
    tick();
    check("rc_addr", 64'(bus.mem_addr_out), 64'h200);
    check("rc_read", 64'(bus.mem_read_out), 64'd1);

    // ---- reset while fetching with three words buffered ----
    do_reset();
    bus.mem_valid_in = 1'b1; bus.ins_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    bus.mem_valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    bus.mem_valid_in = 1'b1;
    tick();
    check("late_valid_ignored", 64'(fifo_count), 64'd0);
    check("restart_state", 64'(state), 64'd1);
    check("restart_addr", 64'(bus.mem_addr_out), 64'd0);

    // ---- randomized run against the instruction-stream model ----
    do_reset();
    exp_pc = 32'h0;
    prev_pend = 1'b0;
    prev_addr = '0;
    pops = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) halt = ~halt;
      redir = ($urandom_range(0, 49) == 0);
      raddr = $urandom;
      bus.ins_ready_in = ($urandom_range(0, 3) != 0);
      bus.mem_valid_in = ($urandom_range(0, 2) == 0);
      // An uncompleted request must hold its address
      if (prev_pend) begin
        check("hold_read", 64'(bus.mem_read_out), 64'd1);
        check("hold_addr", 64'(bus.mem_addr_out), 64'(prev_addr));
      end
      check("count_bound", 64'(fifo_count > 3'(DEPTH)), 64'd0);
      if (bus.ins_valid_out && bus.ins_ready_in) begin
        check("rnd_pc", 64'(bus.ins_pc_out), 64'(exp_pc));
        check("rnd_data", 64'(bus.ins_data_out), 64'(memfn(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redir) exp_pc = raddr & ~32'd3;
      prev_pend = bus.mem_read_out && !bus.mem_valid_in && !redir;
      prev_addr = bus.mem_addr_out;
      tick();
    end
    redir = 1'b0;
    check("rnd_progress", 64'(pops > 200), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
